instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction-fetch stage that sits directly downstream of the combinational instruction ROM in the RV32I integrated core. It owns the program counter and drives the ROM word address. It captures each returned instruction together with its PC into a small FIFO and presents them to decode over a valid/ready handshake. It also supports control-flow redirects (branch/jump targets) with a buffer flush, and halts with a fault when the PC leaves ROM space.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2: fetch buffer entries; power of two, ≥2.
- ROM_WORD_SIZE, 256: instruction ROM depth in words; the valid fetch range is [0, ROM_WORD_SIZE*4).

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_addr  out  32  byte address to ROM, equal to fetch_pc
- instr_code  in  32  ROM read data, combinational from instr_addr
- redirect_valid  in  1  single-cycle request to change PC
- redirect_pc  in  32  new target byte address
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- fetch_fault  out  1  PC out of ROM range; fetching halted
- align_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

## Operation

- fetch_pc register. instr_addr = fetch_pc.
- The FSM has two states, RUN and HALT.
- RUN behaviour:
  - Push {fetch_pc, instr_code} whenever the FIFO has space, or is full with a pop in the same cycle.
  - On a push, fetch_pc <= fetch_pc + 4. The addition is 32-bit modulo; overflow is not otherwise handled.
- RUN → HALT: fetch_pc ≥ ROM_WORD_SIZE*4 with no redirect. No push in that cycle. fetch_fault is asserted combinationally from the HALT state.
- HALT behaviour:
  - No pushes.
  - The FIFO keeps draining normally.
  - Only a redirect returns the FSM to RUN.
- Pop occurs when out_valid && out_ready.
- Redirect (highest priority):
  - The FIFO flushes (count=0) at the clock edge.
  - The push from that cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - State <= RUN.
  - A pop in the same cycle still counts as accepted by decode.
- align_err is registered: it is high for exactly the cycle after a redirect with nonzero redirect_pc[1:0].
- Reset values:
  - fetch_pc=RESET_PC, state RUN, FIFO empty.
  - out_valid=0, out_pc=0, out_instr=32'h0000_0013 (NOP), fetch_fault=0, align_err=0.
- When empty, out_pc reads 0 and out_instr reads NOP. Decode must qualify on out_valid.

## Timing

- Fetch-to-output latency is 1 cycle. The entry pushed at edge N is visible with out_valid=1 after edge N.
- Reset: first push at the first rising edge after rst_n deasserts, so out_valid rises one cycle after release.
- Steady state with out_ready held high: one instruction per cycle, out_pc incrementing by 4.
- Backpressure: with out_ready=0 the FIFO fills in FIFO_DEPTH cycles, then fetch_pc freezes. out_pc/out_instr hold stable while out_valid && !out_ready.
- Redirect penalty: redirect at edge N ⇒ out_valid=0 after N; first target instruction valid after edge N+1.
- Reset mid-operation: asynchronous clear of all state. No partial entries survive.

## Structure

- Package rv32i_fetch_pkg holds:
  - typedef fetch_entry_t (pc[31:0], instr[31:0])
  - localparam NOP_INSTR = 32'h0000_0013
  - enum fetch_state_t {RUN, HALT}
- Sub-module fetch_fifo:
  - Parameterized by depth and entry type.
  - Push/pop/flush ports, with count, full and empty outputs.
  - Same clk/rst_n.
- Top-level instr_fetch_unit contains the PC register, FSM, redirect and fault logic.

## Test plan

- Reset and stream:
  - Stimulus: RESET_PC=0, ROM word i = ADDI(x1,x0,i), out_ready=1.
  - Required: out_pc 0,4,8,… on consecutive cycles, out_instr matching; out_valid first high one cycle after reset release.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles, then 1.
  - Required: instr_addr stops at 0x8 (FIFO_DEPTH=2); out_pc=0 held stable; no duplicate or lost PCs after release.
- Redirect:
  - Stimulus: redirect_valid=1, redirect_pc=0x24 while FIFO full.
  - Required: out_valid=0 the next cycle; following cycle out_pc=0x24; no stale 0x8 entry delivered.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x16.
  - Required: align_err high one cycle; fetch resumes at 0x14.
- Out-of-range:
  - Stimulus: ROM_WORD_SIZE=4, stream from 0.
  - Required: PCs 0x0–0xC delivered; fetch_fault=1 when fetch_pc=0x10; no further pushes; redirect to 0x0 clears the fault and restarts.
- Asynchronous reset:
  - Stimulus: rst_n low mid-cycle during streaming.
  - Required: out_valid, fetch_fault and align_err drop immediately; instr_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the RV32I fetch stage.
// Fetch buffer entry, NOP encoding and fetch FSM states.
package rv32i_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small power-of-two circular buffer holding fetched entries.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush) begin
        mem_q[wr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM address, buffers
// {pc, instr} for decode, handles redirects and out-of-ROM halts.
module instr_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned ROM_WORD_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault,
  output logic        align_err
);

  localparam logic [32:0] ROM_BYTES = 33'(ROM_WORD_SIZE) * 33'd4;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         align_q, align_d;

  logic         in_range;
  logic         pop, push, halt_go;
  logic         full, empty;
  logic [CW-1:0] count;
  fetch_entry_t wr_entry, head;

  assign instr_addr  = pc_q;
  assign fetch_fault = state_q == HALT;
  assign align_err   = align_q;

  assign in_range = {1'b0, pc_q} < ROM_BYTES;
  assign out_valid = count != '0;
  assign pop      = out_valid && out_ready;

  // Mutually exclusive so the decoder below stays unique.
  assign push    = (state_q == RUN) && in_range && !redirect_valid
                 && (!full || pop);
  assign halt_go = (state_q == RUN) && !in_range && !redirect_valid;

  assign wr_entry = '{pc: pc_q, instr: instr_code};

  assign out_pc    = empty ? 32'h0 : head.pc;
  assign out_instr = empty ? NOP_INSTR : head.instr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    align_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    unique case (1'b1)
      redirect_valid: begin
        pc_d    = {redirect_pc[31:2], 2'b00};
        state_d = RUN;
      end
      halt_go: state_d = HALT;
      push:    pc_d    = pc_q + 32'd4;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      align_q <= align_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a
// queue-based reference model of the fetch buffer and PC.
module tb_instr_fetch_unit;
  import rv32i_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ROMW   = 16;
  localparam logic [31:0] ROMB   = ROMW * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_addr, instr_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        fetch_fault, align_err;

  always #5 clk = ~clk;

  // ROM word i holds ADDI x1, x0, i
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[13:2], 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  assign instr_code = rom(instr_addr);

  instr_fetch_unit #(
    .RESET_PC      (RST_PC),
    .FIFO_DEPTH    (DEPTH),
    .ROM_WORD_SIZE (ROMW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_addr     (instr_addr),
    .instr_code     (instr_code),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault),
    .align_err      (align_err)
  );

  int n_vec = 0;
  int n_err = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  mpc;
  bit           mhalt, malign;
  bit           mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares presented state and retires accepted entries.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("instr_addr", instr_addr, mpc);
      chk("fetch_fault", 32'(fetch_fault), 32'(mhalt));
      chk("align_err", 32'(align_err), 32'(malign));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (!out_valid) begin
        chk("idle_pc", out_pc, 32'h0);
        chk("idle_instr", out_instr, NOP_INSTR);
      end else if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", out_instr, exp_q[0].instr);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Model: one clock edge of the fetch stage with the given inputs.
  task automatic model_edge(input bit rv, input logic [31:0] tgt);
    fetch_entry_t e;
    if (rv) begin
      exp_q.delete();
      mpc    = {tgt[31:2], 2'b00};
      mhalt  = 0;
      malign = tgt[1:0] != 2'b00;
    end else begin
      malign = 0;
      if (!mhalt) begin
        if (mpc >= ROMB) begin
          mhalt = 1;
        end else if (exp_q.size() < DEPTH) begin
          e.pc    = mpc;
          e.instr = rom(mpc);
          exp_q.push_back(e);
          mpc = mpc + 4;
        end
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mpc    = RST_PC;
    mhalt  = 0;
    malign = 0;
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_addr", instr_addr, RST_PC);
    chk("rst_instr", out_instr, NOP_INSTR);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    #2 rst_n = 1'b1;
    mon_en = 1;

    for (int c = 0; c < 2400; c++) begin
      @(posedge clk);
      #1;
      model_edge(redirect_valid, redirect_pc);

      if (c == 1200) begin
        mon_en = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_fault", 32'(fetch_fault), 32'h0);
        chk("arst_align", 32'(align_err), 32'h0);
        chk("arst_addr", instr_addr, RST_PC);
        model_reset();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1;
        continue;
      end

      redirect_valid = 1'b0;
      if (c < 20) begin
        out_ready = 1'b1;
      end else if (c < 26) begin
        out_ready = 1'b0;
        if (c == 24) begin
          redirect_valid = 1'b1;
          redirect_pc    = 32'h24;
        end
      end else if (c == 30) begin
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h16;
      end else if (c < 60) begin
        out_ready = 1'b1;
      end else begin
        out_ready = $urandom_range(0, 99) < ((c / 100) % 2 ? 80 : 35);
        if ($urandom_range(0, 99) < 7) begin
          redirect_valid = 1'b1;
          redirect_pc    = $urandom_range(0, 79);
        end
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
